// File: rtl/pipe_hazard_int_ctrl.sv
// Pipeline control FSM: stage-register enables/clears for load-use stalls, flushes, interrupt entry and eret.
// Outputs are combinational in the current cycle; the state (RUN/VECTOR/ISR, bubble count, in-service) updates on the clock edge.
module pipe_hazard_int_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] IDRs,
  input  logic [REG_AW-1:0] IDRt,
  input  logic              IDUsesRs,
  input  logic              IDUsesRt,
  input  logic              IDValid,
  input  logic              ExMemRd,
  input  logic [REG_AW-1:0] ExWA,
  input  logic              BranchTaken,
  input  logic              EretEx,
  input  logic              IntReq,
  input  logic              IntEn,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDClear,
  output logic              IDEXWrite,
  output logic              IDEXClear,
  output logic              EPCWrite,
  output logic              PCSelInt,
  output logic              IntAck,
  output logic              InService
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] VECTOR = 2'd1;
  localparam logic [1:0] ISR    = 2'd2;

  localparam logic [CNT_W-1:0] BUB_LOAD = CNT_W'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] BUB_ONE  = CNT_W'(1);

  logic [1:0]       st, st_nxt;
  logic [CNT_W-1:0] bub_cnt, bub_nxt;
  logic             in_service, in_service_nxt;
  logic             lu, flush, stall, accept;

  always_comb begin
    lu = ExMemRd && (ExWA != '0) &&
         (((ExWA == IDRs) && IDUsesRs) || ((ExWA == IDRt) && IDUsesRt));
    flush  = BranchTaken || EretEx;
    // EX holds a bubble during VECTOR, so hazards are meaningless there
    stall  = (st != VECTOR) && !flush && (lu || (bub_cnt != '0));
    accept = (st == RUN) && IntReq && IntEn && !in_service && IDValid && !flush && !stall;
  end

  always_comb begin
    st_nxt         = st;
    bub_nxt        = bub_cnt;
    in_service_nxt = in_service;
    case (st)
      VECTOR: begin
        st_nxt         = ISR;
        in_service_nxt = 1'b1;
        bub_nxt        = '0;
      end
      RUN, ISR: begin
        if (flush) begin
          bub_nxt = '0;
          if (EretEx && (st == ISR)) begin
            st_nxt         = RUN;
            in_service_nxt = 1'b0;
          end
        end else if (stall) begin
          bub_nxt = (bub_cnt == '0) ? BUB_LOAD : (bub_cnt - BUB_ONE);
        end else if (accept) begin
          st_nxt = VECTOR;
        end
      end
      default: begin
        st_nxt         = RUN;
        bub_nxt        = '0;
        in_service_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= RUN;
      bub_cnt    <= '0;
      in_service <= 1'b0;
    end else begin
      st         <= st_nxt;
      bub_cnt    <= bub_nxt;
      in_service <= in_service_nxt;
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    IFIDWrite = 1'b0;
    IFIDClear = 1'b0;
    IDEXWrite = 1'b0;
    IDEXClear = 1'b0;
    EPCWrite  = 1'b0;
    PCSelInt  = 1'b0;
    IntAck    = 1'b0;
    InService = 1'b0;
    if (!rst) begin
      IDEXWrite = 1'b1;
      IFIDWrite = 1'b1;
      InService = in_service;
      if (st == VECTOR) begin
        PCSelInt  = 1'b1;
        PCWrite   = 1'b1;
        IntAck    = 1'b1;
        IFIDClear = 1'b1;
        IDEXClear = 1'b1;
      end else if (flush) begin
        PCWrite   = 1'b1;
        IFIDClear = 1'b1;
        IDEXClear = 1'b1;
      end else if (stall) begin
        IFIDWrite = 1'b0;
        IDEXClear = 1'b1;
      end else if (accept) begin
        // ID instruction is squashed and its PC saved; it re-executes after eret
        EPCWrite  = 1'b1;
        IFIDClear = 1'b1;
        IDEXClear = 1'b1;
      end else begin
        PCWrite = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_int_ctrl.sv
// Directed bench for pipe_hazard_int_ctrl; two instances (1 and 3 load-use bubbles) share the same stimulus.
module tb_pipe_hazard_int_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] IDRs, IDRt, ExWA;
  logic       IDUsesRs, IDUsesRt, IDValid, ExMemRd, BranchTaken, EretEx, IntReq, IntEn;

  logic PCWrite1, IFIDWrite1, IFIDClear1, IDEXWrite1, IDEXClear1, EPCWrite1, PCSelInt1, IntAck1, InService1;
  logic PCWrite3, IFIDWrite3, IFIDClear3, IDEXWrite3, IDEXClear3, EPCWrite3, PCSelInt3, IntAck3, InService3;
  logic [8:0] o1, o3;

  int checks = 0;
  int errors = 0;

  // bit order: PCWrite IFIDWrite IFIDClear IDEXWrite IDEXClear EPCWrite PCSelInt IntAck InService
  localparam logic [8:0] ZERO = 9'b000000000;
  localparam logic [8:0] DEF  = 9'b110100000;
  localparam logic [8:0] STL  = 9'b000110000;
  localparam logic [8:0] FLS  = 9'b111110000;
  localparam logic [8:0] ACC  = 9'b011111000;
  localparam logic [8:0] VEC  = 9'b111110110;
  localparam logic [8:0] DEFI = 9'b110100001;
  localparam logic [8:0] FLSI = 9'b111110001;

  assign o1 = {PCWrite1, IFIDWrite1, IFIDClear1, IDEXWrite1, IDEXClear1, EPCWrite1, PCSelInt1, IntAck1, InService1};
  assign o3 = {PCWrite3, IFIDWrite3, IFIDClear3, IDEXWrite3, IDEXClear3, EPCWrite3, PCSelInt3, IntAck3, InService3};

  always #5 clk = ~clk;

  pipe_hazard_int_ctrl #(.REG_AW(5), .LU_BUBBLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDValid(IDValid), .ExMemRd(ExMemRd), .ExWA(ExWA), .BranchTaken(BranchTaken), .EretEx(EretEx),
    .IntReq(IntReq), .IntEn(IntEn), .PCWrite(PCWrite1), .IFIDWrite(IFIDWrite1), .IFIDClear(IFIDClear1),
    .IDEXWrite(IDEXWrite1), .IDEXClear(IDEXClear1), .EPCWrite(EPCWrite1), .PCSelInt(PCSelInt1),
    .IntAck(IntAck1), .InService(InService1)
  );

  pipe_hazard_int_ctrl #(.REG_AW(5), .LU_BUBBLES(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDValid(IDValid), .ExMemRd(ExMemRd), .ExWA(ExWA), .BranchTaken(BranchTaken), .EretEx(EretEx),
    .IntReq(IntReq), .IntEn(IntEn), .PCWrite(PCWrite3), .IFIDWrite(IFIDWrite3), .IFIDClear(IFIDClear3),
    .IDEXWrite(IDEXWrite3), .IDEXClear(IDEXClear3), .EPCWrite(EPCWrite3), .PCSelInt(PCSelInt3),
    .IntAck(IntAck3), .InService(InService3)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    IDRs = 5'd0; IDRt = 5'd0; ExWA = 5'd0;
    IDUsesRs = 1'b0; IDUsesRt = 1'b0; IDValid = 1'b1; ExMemRd = 1'b0;
    BranchTaken = 1'b0; EretEx = 1'b0; IntReq = 1'b0; IntEn = 1'b0;
  endtask

  task automatic set_lu_rs();
    ExMemRd = 1'b1; ExWA = 5'd5; IDRs = 5'd5; IDUsesRs = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    BranchTaken = 1'b1;
    set_lu_rs();
    #1 chk("reset_1", o1, ZERO);
    chk("reset_3", o3, ZERO);

    next_cycle(); rst = 1'b0;
    #1 chk("run_default_1", o1, DEF);
    chk("run_default_3", o3, DEF);

    // load-use on rs: 1 vs 3 bubbles from a single-cycle hit
    next_cycle(); set_lu_rs();
    #1 chk("lu_rs_1", o1, STL);
    chk("lu_rs_3", o3, STL);
    next_cycle();
    #1 chk("lu_end_1", o1, DEF);
    chk("lu_bub2_3", o3, STL);
    next_cycle();
    #1 chk("lu_after_1", o1, DEF);
    chk("lu_bub3_3", o3, STL);
    next_cycle();
    #1 chk("lu_end_3", o3, DEF);

    next_cycle(); ExMemRd = 1'b1; ExWA = 5'd0; IDRs = 5'd0; IDUsesRs = 1'b1;
    #1 chk("lu_r0_1", o1, DEF);
    chk("lu_r0_3", o3, DEF);
    next_cycle(); ExMemRd = 1'b1; ExWA = 5'd7; IDRt = 5'd7; IDRs = 5'd3; IDUsesRs = 1'b1;
    #1 chk("lu_rt_unused", o1, DEF);

    // rt hit, then branch in the second stall cycle of the 3-bubble instance
    next_cycle(); ExMemRd = 1'b1; ExWA = 5'd7; IDRt = 5'd7; IDUsesRt = 1'b1;
    #1 chk("lu_rt_3", o3, STL);
    next_cycle(); BranchTaken = 1'b1;
    #1 chk("br_in_stall_3", o3, FLS);
    chk("br_1", o1, FLS);
    next_cycle();
    #1 chk("stall_killed_3", o3, DEF);

    next_cycle(); set_lu_rs(); BranchTaken = 1'b1;
    #1 chk("br_and_lu_3", o3, FLS);
    next_cycle();
    #1 chk("br_and_lu_after_3", o3, DEF);
    chk("br_and_lu_after_1", o1, DEF);

    next_cycle(); IntReq = 1'b1; IntEn = 1'b1; IDValid = 1'b0;
    #1 chk("int_no_idvalid", o1, DEF);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b0;
    #1 chk("int_disabled", o1, DEF);

    // interrupt entry, nesting blocked, eret, immediate re-entry
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("int_accept_1", o1, ACC);
    chk("int_accept_3", o3, ACC);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("vector_1", o1, VEC);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("isr_first_1", o1, DEFI);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("isr_no_nest_1", o1, DEFI);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1; EretEx = 1'b1;
    #1 chk("eret_flush_1", o1, FLSI);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("reaccept_1", o1, ACC);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("revector_1", o1, VEC);
    next_cycle();
    #1 chk("isr_idle_1", o1, DEFI);
    next_cycle(); EretEx = 1'b1;
    #1 chk("eret2_1", o1, FLSI);
    next_cycle();
    #1 chk("run_after_eret_1", o1, DEF);
    chk("run_after_eret_3", o3, DEF);

    // interrupt deferred behind a load-use stall, then reset during VECTOR
    next_cycle(); set_lu_rs(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("defer_stall_1", o1, STL);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("defer_accept_1", o1, ACC);
    chk("defer_still_stall_3", o3, STL);
    next_cycle(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("defer_vector_1", o1, VEC);
    #1 rst = 1'b1;
    #1 chk("rst_in_vector_1", o1, ZERO);
    chk("rst_in_vector_3", o3, ZERO);
    next_cycle(); rst = 1'b0;
    #1 chk("after_rst_1", o1, DEF);
    chk("after_rst_3", o3, DEF);
    next_cycle();
    #1 chk("after_rst_run_1", o1, DEF);

    // request withdrawn while deferred: no acknowledge
    next_cycle(); set_lu_rs(); IntReq = 1'b1; IntEn = 1'b1;
    #1 chk("drop_stall_1", o1, STL);
    next_cycle(); IntEn = 1'b1;
    #1 chk("drop_no_ack_1", o1, DEF);
    next_cycle();
    #1 chk("drop_no_vector_1", o1, DEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
